// File: rtl/hex_display_scheduler.sv
// Shares the HEX/LEDR display word between the HPS PIO word and a timed local status word,
// with a debounced pushbutton that toggles a freeze of the current word.
module hex_display_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 100000000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [31:0] hps_word,
  input  logic [31:0] status_word,
  input  logic        status_valid,
  input  logic        freeze_key_n,
  output logic [31:0] disp_word,
  output logic [1:0]  disp_src,
  output logic        hps_changed,
  output logic        status_pending
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TmW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmW-1:0] TmFull = TmW'(HOLD_CYCLES - 1);

  // Encodings double as the disp_src code.
  typedef enum logic [1:0] {
    StShowHps    = 2'd0,
    StShowStatus = 2'd1,
    StFrozen     = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic           key_meta_q, key_sync_q, key_db_q, key_db_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           press;

  logic [31:0]    disp_word_q, disp_word_d;
  logic [1:0]     disp_src_q, disp_src_d;
  logic [31:0]    status_q, status_d;
  logic           pending_q, pending_d;
  logic [TmW-1:0] timer_q, timer_d;
  logic [31:0]    hps_prev_q;
  logic           hps_changed_q;

  // Key path: synchronizer, debounce counter, press edge.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      key_db_q   <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      key_meta_q <= freeze_key_n;
      key_sync_q <= key_meta_q;
      key_db_q   <= key_db_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // The count restarts whenever the synchronized level agrees with the debounced one.
  always_comb begin
    db_cnt_d = '0;
    key_db_d = key_db_q;
    press    = 1'b0;
    if (key_sync_q != key_db_q) begin
      if (db_cnt_q == DbLast) begin
        key_db_d = key_sync_q;
        press    = ~key_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // State register and datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q       <= StShowHps;
      disp_word_q   <= '0;
      disp_src_q    <= '0;
      status_q      <= '0;
      pending_q     <= 1'b0;
      timer_q       <= '0;
      hps_prev_q    <= '0;
      hps_changed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      disp_word_q   <= disp_word_d;
      disp_src_q    <= disp_src_d;
      status_q      <= status_d;
      pending_q     <= pending_d;
      timer_q       <= timer_d;
      hps_prev_q    <= hps_word;
      hps_changed_q <= (hps_word != hps_prev_q);
    end
  end

  // Next-state: a press always wins over status_valid for the transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StShowHps: begin
        if (press)             state_d = StFrozen;
        else if (status_valid) state_d = StShowStatus;
      end
      StShowStatus: begin
        if (press)                                state_d = StFrozen;
        else if (!status_valid && timer_q == '0) state_d = StShowHps;
      end
      StFrozen: begin
        if (press) state_d = (status_valid || pending_q) ? StShowStatus : StShowHps;
      end
      default: state_d = StShowHps;
    endcase
  end

  // Output/datapath next values.
  always_comb begin
    disp_word_d = disp_word_q;
    status_d    = status_valid ? status_word : status_q;
    pending_d   = pending_q;
    timer_d     = timer_q;
    disp_src_d  = state_d;
    unique case (state_q)
      StShowHps: begin
        if (press) begin
          pending_d = status_valid;
        end else if (status_valid) begin
          timer_d     = TmFull;
          disp_word_d = status_word;
        end else begin
          disp_word_d = hps_word;
        end
      end
      StShowStatus: begin
        if (press) begin
          pending_d = status_valid;
          timer_d   = '0;
        end else if (status_valid) begin
          timer_d     = TmFull;
          disp_word_d = status_word;
        end else if (timer_q == '0) begin
          disp_word_d = hps_word;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StFrozen: begin
        if (press) begin
          pending_d = 1'b0;
          if (status_valid || pending_q) begin
            timer_d     = TmFull;
            disp_word_d = status_valid ? status_word : status_q;
          end else begin
            disp_word_d = hps_word;
          end
        end else if (status_valid) begin
          pending_d = 1'b1;
        end
      end
      default: disp_word_d = disp_word_q;
    endcase
  end

  assign disp_word      = disp_word_q;
  assign disp_src       = disp_src_q;
  assign hps_changed    = hps_changed_q;
  assign status_pending = pending_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Randomized and directed bench for hex_display_scheduler against a behavioural model.
module tb_hex_display_scheduler;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Hold = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] hps_word;
  logic [31:0] status_word;
  logic        status_valid;
  logic        freeze_key_n;
  logic [31:0] disp_word;
  logic [1:0]  disp_src;
  logic        hps_changed;
  logic        status_pending;

  always #5 clk = ~clk;

  hex_display_scheduler #(
    .DEBOUNCE_CYCLES(Deb),
    .HOLD_CYCLES    (Hold)
  ) dut (
    .CLOCK_50      (clk),
    .resetn        (resetn),
    .hps_word      (hps_word),
    .status_word   (status_word),
    .status_valid  (status_valid),
    .freeze_key_n  (freeze_key_n),
    .disp_word     (disp_word),
    .disp_src      (disp_src),
    .hps_changed   (hps_changed),
    .status_pending(status_pending)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = HPS, 1 = STATUS, 2 = FROZEN; m_left = display cycles remaining.
  int          m_mode;
  int          m_left;
  logic [31:0] m_word, m_stat, m_prev;
  logic        m_pend, m_db, m_changed;
  bit          m_valid = 1'b0;
  logic        kpipe[$];
  logic        khist[$];

  always @(posedge clk) begin
    logic sync;
    logic press;
    bit   all_diff;
    if (!resetn) begin
      m_mode = 0; m_left = 0; m_word = '0; m_stat = '0; m_prev = '0;
      m_pend = 1'b0; m_db = 1'b1; m_changed = 1'b0;
      kpipe.delete(); kpipe.push_back(1'b1); kpipe.push_back(1'b1);
      khist.delete();
      m_valid = 1'b1;
    end else begin
      // Key seen two clocks late; accepted once the last Deb samples all disagree.
      sync = kpipe.pop_front();
      kpipe.push_back(freeze_key_n);
      khist.push_back(sync);
      if (khist.size() > Deb) void'(khist.pop_front());
      press = 1'b0;
      if (khist.size() == Deb) begin
        all_diff = 1'b1;
        foreach (khist[i]) if (khist[i] == m_db) all_diff = 1'b0;
        if (all_diff) begin
          m_db  = ~m_db;
          press = (m_db == 1'b0);
        end
      end
      if (press) begin
        if (m_mode == 2) begin
          if (status_valid || m_pend) begin
            if (status_valid) m_stat = status_word;
            m_mode = 1; m_left = Hold; m_word = m_stat;
          end else begin
            m_mode = 0; m_word = hps_word;
          end
          m_pend = 1'b0;
        end else begin
          if (status_valid) begin
            m_stat = status_word; m_pend = 1'b1;
          end
          m_mode = 2;
        end
      end else if (status_valid) begin
        m_stat = status_word;
        if (m_mode == 2) m_pend = 1'b1;
        else begin
          m_mode = 1; m_left = Hold; m_word = status_word;
        end
      end else if (m_mode == 0) begin
        m_word = hps_word;
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0; m_word = hps_word;
        end
      end
      m_changed = (hps_word != m_prev);
      m_prev    = hps_word;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_disp_word", disp_word, m_word);
      check("model_disp_src", 32'(disp_src), 32'(m_mode));
      check("model_hps_changed", 32'(hps_changed), 32'(m_changed));
      check("model_status_pending", 32'(status_pending), 32'(m_pend));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_src(input logic [1:0] want, output int n);
    n = 0;
    while (disp_src == want && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_src(input logic [1:0] want, input string name);
    int k;
    k = 0;
    while (disp_src != want && k < 30) begin
      k++;
      tick();
    end
    check(name, 32'(disp_src), 32'(want));
  endtask

  task automatic pulse_status(input logic [31:0] w);
    status_word  = w;
    status_valid = 1'b1;
    tick();
    status_valid = 1'b0;
  endtask

  initial begin
    int          n;
    int          spurious;
    int          key_run;
    logic [31:0] frozen;

    resetn = 1'b0; hps_word = 32'h00AB_CDEF; status_word = '0;
    status_valid = 1'b0; freeze_key_n = 1'b1;
    tick(); tick();
    check("rst_word", disp_word, 32'h0);
    check("rst_src", 32'(disp_src), 32'h0);
    check("rst_changed", 32'(hps_changed), 32'h0);
    check("rst_pending", 32'(status_pending), 32'h0);

    resetn = 1'b1;
    tick();
    check("t1_word", disp_word, 32'h00AB_CDEF);
    check("t1_src", 32'(disp_src), 32'h0);
    check("t1_changed", 32'(hps_changed), 32'h1);
    tick();
    check("t1_changed_once", 32'(hps_changed), 32'h0);

    pulse_status(32'hDEAD_0001);
    check("t2_word", disp_word, 32'hDEAD_0001);
    hps_word = 32'h1111_1111;
    count_src(2'd1, n);
    check("t2_hold_len", 32'(n), 32'd8);
    check("t2_back_word", disp_word, 32'h1111_1111);

    pulse_status(32'hDEAD_0001);
    repeat (4) tick();
    pulse_status(32'h0000_0002);
    check("t3_word", disp_word, 32'h2);
    count_src(2'd1, n);
    check("t3_hold_len", 32'(n), 32'd8);

    hps_word = 32'h1234_5678;
    tick();
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      freeze_key_n = 1'b0; tick(); if (disp_src != 2'd0) spurious++;
      tick(); if (disp_src != 2'd0) spurious++;
      freeze_key_n = 1'b1; tick(); if (disp_src != 2'd0) spurious++;
      tick(); if (disp_src != 2'd0) spurious++;
    end
    check("t4_bounce_no_press", 32'(spurious), 32'd0);
    freeze_key_n = 1'b0;
    wait_src(2'd2, "t4_frozen_src");
    check("t4_frozen_word", disp_word, 32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      hps_word = $urandom;
      tick();
    end
    check("t4_hold_frozen", disp_word, 32'h1234_5678);
    check("t4_one_press", 32'(disp_src), 32'd2);
    freeze_key_n = 1'b1;
    repeat (10) tick();
    check("t4_release_src", 32'(disp_src), 32'd2);
    freeze_key_n = 1'b0;
    wait_src(2'd0, "t4_unfreeze_src");
    check("t4_unfreeze_word", disp_word, hps_word);
    freeze_key_n = 1'b1;
    repeat (10) tick();

    freeze_key_n = 1'b0;
    wait_src(2'd2, "t5_frozen_src");
    frozen = disp_word;
    pulse_status(32'h0000_0077);
    check("t5_pending", 32'(status_pending), 32'h1);
    check("t5_word_held", disp_word, frozen);
    freeze_key_n = 1'b1;
    repeat (10) tick();
    freeze_key_n = 1'b0;
    wait_src(2'd1, "t5_status_src");
    check("t5_word", disp_word, 32'h77);
    check("t5_pending_clr", 32'(status_pending), 32'h0);
    count_src(2'd1, n);
    check("t5_hold_len", 32'(n), 32'd8);
    freeze_key_n = 1'b1;
    repeat (10) tick();

    pulse_status(32'h0000_0055);
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    check("t6_hold_rst_word", disp_word, 32'h0);
    check("t6_hold_rst_src", 32'(disp_src), 32'h0);
    resetn = 1'b1;
    tick();
    freeze_key_n = 1'b0;
    repeat (4) tick();
    resetn = 1'b0;
    freeze_key_n = 1'b1;
    tick();
    check("t6_db_rst_word", disp_word, 32'h0);
    check("t6_db_rst_pending", 32'(status_pending), 32'h0);
    resetn = 1'b1;
    spurious = 0;
    repeat (15) begin
      tick();
      if (disp_src == 2'd2) spurious++;
    end
    check("t6_no_spurious_press", 32'(spurious), 32'd0);

    key_run = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) hps_word = $urandom;
      status_valid = ($urandom_range(9) == 0);
      status_word  = $urandom;
      if (key_run == 0) begin
        freeze_key_n = ~freeze_key_n;
        key_run = $urandom_range(12, 1);
      end else begin
        key_run--;
      end
      resetn = ($urandom_range(499) != 0);
      tick();
    end
    status_valid = 1'b0;
    resetn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
